// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester unified memory port arbiter.
// Holds the FSM state encoding, the requester id and the latency counter width.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_DBG  = 1'b1
  } req_id_t;

  // Wide enough for a WAIT down-count of MEM_LATENCY-1 with MEM_LATENCY up to 3.
  localparam int LAT_CNT_W = 2;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Two-input round-robin picker with a last-grant pointer.
// Grants are combinational and one-hot; the pointer moves only when a grant is issued.
module rr_picker
  import mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req_core,
  input  logic req_dbg,
  output logic gnt_core,
  output logic gnt_dbg
);

  req_id_t last_r;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    gnt_core = 1'b0;
    gnt_dbg  = 1'b0;
    if (en) begin
      if (req_core && req_dbg) begin
        if (last_r == REQ_CORE) begin
          gnt_dbg = 1'b1;
        end else begin
          gnt_core = 1'b1;
        end
      end else begin
        gnt_core = req_core;
        gnt_dbg  = req_dbg;
      end
    end else begin
      gnt_core = 1'b0;
      gnt_dbg  = 1'b0;
    end
  end

  // Reset marks debug as last granted so the core wins the first tie.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_r <= REQ_DBG;
    end else if (gnt_core) begin
      last_r <= REQ_CORE;
    end else if (gnt_dbg) begin
      last_r <= REQ_DBG;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the core and debug/loader requesters onto one memory port,
// sequencing a single access at a time through IDLE/ACCESS/WAIT/RESP.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam bit NO_WAIT = (MEM_LATENCY == 0);
  localparam logic [LAT_CNT_W-1:0] WAIT_LOAD =
    LAT_CNT_W'((MEM_LATENCY > 0) ? (MEM_LATENCY - 1) : 0);

  state_t                state_r, state_n;
  req_id_t               owner_r;
  logic                  we_r;
  logic [ADDR_W-1:0]     addr_r;
  logic [DATA_W-1:0]     wdata_r;
  logic [DATA_W-1:0]     core_rdata_r, dbg_rdata_r;
  logic [LAT_CNT_W-1:0]  cnt_r, cnt_n;
  logic                  pick_en_s, capture_s, grant_s;

  // Grants are suppressed while reset is asserted so reset wins over a same-cycle grant.
  assign pick_en_s = reset && ((state_r == IDLE) || (state_r == RESP));
  assign grant_s   = core_gnt || dbg_gnt;

  rr_picker u_picker (
    .clk      (clk),
    .reset    (reset),
    .en       (pick_en_s),
    .req_core (core_req),
    .req_dbg  (dbg_req),
    .gnt_core (core_gnt),
    .gnt_dbg  (dbg_gnt)
  );

  // Next-state logic; capture_s marks the cycle whose end samples mem_rdata.
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    capture_s = 1'b0;
    case (state_r)
      IDLE, RESP: begin
        if (grant_s) begin
          state_n = ACCESS;
        end else begin
          state_n = IDLE;
        end
      end
      ACCESS: begin
        if (NO_WAIT) begin
          state_n   = RESP;
          capture_s = 1'b1;
        end else begin
          state_n = WAIT;
          cnt_n   = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_r == {LAT_CNT_W{1'b0}}) begin
          state_n   = RESP;
          capture_s = 1'b1;
        end else begin
          cnt_n = cnt_r - {{(LAT_CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, request capture on the grant edge and per-requester read data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= IDLE;
      cnt_r        <= {LAT_CNT_W{1'b0}};
      owner_r      <= REQ_CORE;
      we_r         <= 1'b0;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {DATA_W{1'b0}};
      core_rdata_r <= {DATA_W{1'b0}};
      dbg_rdata_r  <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      if (grant_s) begin
        owner_r <= dbg_gnt ? REQ_DBG : REQ_CORE;
        we_r    <= dbg_gnt ? dbg_we : core_we;
        addr_r  <= dbg_gnt ? dbg_addr : core_addr;
        wdata_r <= dbg_gnt ? dbg_wdata : core_wdata;
      end
      if (capture_s && !we_r) begin
        if (owner_r == REQ_DBG) begin
          dbg_rdata_r <= mem_rdata;
        end else begin
          core_rdata_r <= mem_rdata;
        end
      end
    end
  end

  assign mem_en      = (state_r == ACCESS);
  assign mem_we      = (state_r == ACCESS) && we_r;
  assign mem_addr    = addr_r;
  assign mem_wdata   = wdata_r;
  assign core_rvalid = (state_r == RESP) && (owner_r == REQ_CORE);
  assign dbg_rvalid  = (state_r == RESP) && (owner_r == REQ_DBG);
  assign core_rdata  = core_rdata_r;
  assign dbg_rdata   = dbg_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios on L=1, L=0 and L=3 builds
// plus randomized traffic checked against a cycle-timing reference model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        core_req = 1'b0, core_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] core_addr = 32'd0, core_wdata = 32'd0, dbg_addr = 32'd0, dbg_wdata = 32'd0;

  logic        core_gnt, core_rvalid, dbg_gnt, dbg_rvalid, mem_en, mem_we;
  logic [31:0] core_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        core_gnt_0, core_rvalid_0, dbg_gnt_0, dbg_rvalid_0, mem_en_0, mem_we_0;
  logic [31:0] core_rdata_0, dbg_rdata_0, mem_addr_0, mem_wdata_0, mem_rdata_0;
  logic        core_gnt_3, core_rvalid_3, dbg_gnt_3, dbg_rvalid_3, mem_en_3, mem_we_3;
  logic [31:0] core_rdata_3, dbg_rdata_3, mem_addr_3, mem_wdata_3, mem_rdata_3;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] rd_q;
  logic        rd_v = 1'b0;
  logic [31:0] p3 [0:2];
  logic [2:0]  v3 = 3'b000;

  always #5 clk = ~clk;

  function automatic logic [31:0] hashf(input logic [31:0] a);
    return (a * 32'h9e37_79b1) ^ 32'h1234_5678;
  endfunction

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u_dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata));

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(0)) u_dut_l0 (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt_0), .core_rvalid(core_rvalid_0), .core_rdata(core_rdata_0),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt_0), .dbg_rvalid(dbg_rvalid_0), .dbg_rdata(dbg_rdata_0),
    .mem_en(mem_en_0), .mem_we(mem_we_0), .mem_addr(mem_addr_0), .mem_wdata(mem_wdata_0),
    .mem_rdata(mem_rdata_0));

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) u_dut_l3 (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt_3), .core_rvalid(core_rvalid_3), .core_rdata(core_rdata_3),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt_3), .dbg_rvalid(dbg_rvalid_3), .dbg_rdata(dbg_rdata_3),
    .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
    .mem_rdata(mem_rdata_3));

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= hashf(i);
    mem[42] <= 32'hdead_beef;
  end

  // One-cycle-latency memory; data is only valid in the cycle after the enable.
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    rd_q <= mem[mem_addr[7:0]];
    rd_v <= mem_en && !mem_we;
  end
  assign mem_rdata = rd_v ? rd_q : 32'hbad0_bad0;

  assign mem_rdata_0 = mem_en_0 ? hashf(mem_addr_0) : 32'hbad0_bad0;

  always @(posedge clk) begin
    v3    <= {v3[1:0], mem_en_3};
    p3[0] <= mem_addr_3;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_rdata_3 = v3[2] ? hashf(p3[2]) : 32'hbad0_bad0;

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b0; core_req = 1'b0; dbg_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b0; core_req = 1'b1; dbg_req = 1'b1; core_we = 1'b1; dbg_we = 1'b1;
    core_addr = 32'h55; core_wdata = 32'h1; dbg_addr = 32'h66; dbg_wdata = 32'h2;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, mem_en, mem_we} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000",
               {core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, mem_en, mem_we});
    else n_pass++;
    n_checks++;
    if ({core_rdata, dbg_rdata, mem_addr, mem_wdata} !== 128'd0)
      $display("FAIL reset_data: got %h %h %h %h want 0", core_rdata, dbg_rdata, mem_addr, mem_wdata);
    else n_pass++;
    n_checks++;
    if ({core_gnt_0, mem_en_0, core_gnt_3, mem_en_3} !== 4'b0)
      $display("FAIL reset_lat_builds: got %b want 0000", {core_gnt_0, mem_en_0, core_gnt_3, mem_en_3});
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1; core_req = 1'b0; dbg_req = 1'b0; core_we = 1'b0; dbg_we = 1'b0;
  endtask

  task automatic test_core_read();
    @(posedge clk); #1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h2a;
    @(negedge clk);
    n_checks++;
    if ({core_gnt, dbg_gnt} !== 2'b10) $display("FAIL read_gnt: got %b want 10", {core_gnt, dbg_gnt});
    else n_pass++;
    @(posedge clk); #1 core_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_en, mem_we, mem_addr} !== {2'b10, 32'h2a})
      $display("FAIL read_access: got en=%b we=%b addr=%h want 1 0 2a", mem_en, mem_we, mem_addr);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({core_rvalid, dbg_rvalid, mem_en} !== 3'b000)
      $display("FAIL read_wait: got %b want 000", {core_rvalid, dbg_rvalid, mem_en});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({core_rvalid, dbg_rvalid, core_rdata} !== {2'b10, 32'hdead_beef})
      $display("FAIL read_resp: got rv=%b drv=%b data=%h want 1 0 deadbeef", core_rvalid, dbg_rvalid, core_rdata);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({core_rvalid, core_rdata} !== {1'b0, 32'hdead_beef})
      $display("FAIL read_hold: got rv=%b data=%h want 0 deadbeef", core_rvalid, core_rdata);
    else n_pass++;
  endtask

  task automatic test_dbg_write_core_read();
    @(posedge clk); #1;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h10; dbg_wdata = 32'hcafe_f00d;
    @(negedge clk);
    n_checks++;
    if ({core_gnt, dbg_gnt} !== 2'b01) $display("FAIL wr_gnt: got %b want 01", {core_gnt, dbg_gnt});
    else n_pass++;
    @(posedge clk); #1 dbg_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h10, 32'hcafe_f00d})
      $display("FAIL wr_access: got %b %b %h %h want 1 1 10 cafef00d", mem_en, mem_we, mem_addr, mem_wdata);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({mem_en, mem_we} !== 2'b00) $display("FAIL wr_wait_we: got %b want 00", {mem_en, mem_we});
    else n_pass++;
    @(posedge clk); #1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
    @(negedge clk);
    n_checks++;
    if ({dbg_rvalid, core_rvalid, core_gnt, dbg_rdata} !== {3'b101, 32'd0})
      $display("FAIL wr_resp: got drv=%b crv=%b cgnt=%b drd=%h want 1 0 1 0", dbg_rvalid, core_rvalid, core_gnt, dbg_rdata);
    else n_pass++;
    @(posedge clk); #1 core_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_en, mem_we, mem_addr} !== {2'b10, 32'h10})
      $display("FAIL rd_after_wr_access: got %b %b %h want 1 0 10", mem_en, mem_we, mem_addr);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({core_rvalid, core_rdata} !== {1'b1, 32'hcafe_f00d})
      $display("FAIL rd_after_wr_data: got rv=%b data=%h want 1 cafef00d", core_rvalid, core_rdata);
    else n_pass++;
  endtask

  task automatic test_alternate();
    int prev_c, n_grants;
    logic want_dbg;
    apply_reset();
    prev_c = -1; n_grants = 0; want_dbg = 1'b0;
    @(posedge clk); #1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h4;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      n_checks++;
      if ((core_gnt && dbg_gnt) || (core_rvalid && dbg_rvalid))
        $display("FAIL alt_onehot: cycle %0d gnt=%b%b rv=%b%b want one-hot", c, core_gnt, dbg_gnt, core_rvalid, dbg_rvalid);
      else n_pass++;
      if (core_gnt || dbg_gnt) begin
        n_checks++;
        if (dbg_gnt !== want_dbg || c != ((prev_c < 0) ? 0 : prev_c + 3))
          $display("FAIL alt_grant: cycle %0d dbg=%b prev=%0d want dbg=%b spacing 3", c, dbg_gnt, prev_c, want_dbg);
        else n_pass++;
        want_dbg = ~want_dbg; prev_c = c; n_grants++;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (n_grants != 5) $display("FAIL alt_count: got %0d grants want 5", n_grants);
    else n_pass++;
    core_req = 1'b0; dbg_req = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h2a;
    @(negedge clk);
    n_checks++;
    if (core_gnt !== 1'b1) $display("FAIL rmid_gnt: got %b want 1", core_gnt);
    else n_pass++;
    @(posedge clk); #1 core_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; core_req = 1'b1; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
    @(negedge clk);
    n_checks++;
    if (core_rvalid !== 1'b0) $display("FAIL rmid_wait_rv: got %b want 0", core_rvalid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, mem_en, mem_we, core_rdata, dbg_rdata, mem_addr, mem_wdata} !== 134'd0)
      $display("FAIL rmid_zero: got %b%b%b%b%b%b %h %h %h %h want all 0", core_gnt, dbg_gnt, core_rvalid,
               dbg_rvalid, mem_en, mem_we, core_rdata, dbg_rdata, mem_addr, mem_wdata);
    else n_pass++;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({core_gnt, dbg_gnt} !== 2'b10) $display("FAIL rmid_tie: got %b want 10", {core_gnt, dbg_gnt});
    else n_pass++;
    @(posedge clk); #1 core_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({dbg_gnt, core_rvalid, core_rdata} !== {2'b11, 32'hdead_beef})
      $display("FAIL rmid_next: got dgnt=%b crv=%b data=%h want 1 1 deadbeef", dbg_gnt, core_rvalid, core_rdata);
    else n_pass++;
    @(posedge clk); #1 dbg_req = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_cancel();
    @(posedge clk); #1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h2a;
    @(posedge clk); #1;
    core_req = 1'b0; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20;
    @(negedge clk);
    n_checks++;
    if ({mem_en, dbg_gnt} !== 2'b10) $display("FAIL cancel_access: got en=%b dgnt=%b want 1 0", mem_en, dbg_gnt);
    else n_pass++;
    @(posedge clk); #1 dbg_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if ({dbg_gnt, dbg_rvalid} !== 2'b00)
        $display("FAIL cancel_quiet: cycle %0d got gnt=%b rv=%b want 0 0", k, dbg_gnt, dbg_rvalid);
      else n_pass++;
    end
  endtask

  task automatic test_latency();
    apply_reset();
    @(posedge clk); #1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40;
    @(negedge clk);
    n_checks++;
    if ({core_gnt, core_gnt_0, core_gnt_3} !== 3'b111)
      $display("FAIL lat_gnt: got %b want 111", {core_gnt, core_gnt_0, core_gnt_3});
    else n_pass++;
    @(posedge clk); #1 core_req = 1'b0;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if ({core_rvalid_0, core_rvalid_3} !== {k == 2, k == 5})
        $display("FAIL lat_rvalid: T+%0d got l0=%b l3=%b want %b %b", k, core_rvalid_0, core_rvalid_3, k == 2, k == 5);
      else n_pass++;
      if (k == 2 || k == 5) begin
        n_checks++;
        if ((k == 2 ? core_rdata_0 : core_rdata_3) !== hashf(32'h40))
          $display("FAIL lat_data: T+%0d got %h want %h", k, (k == 2 ? core_rdata_0 : core_rdata_3), hashf(32'h40));
        else n_pass++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    bit busy, last_dbg, p_owner, p_we, c_hold, d_hold, c_gntd, d_gntd, resp, acc, ec, ed;
    int g;
    logic [31:0] p_addr, p_wdata, exp_crd, exp_drd;
    apply_reset();
    ref_mem = mem;
    busy = 0; last_dbg = 1; g = 0; c_hold = 0; d_hold = 0; c_gntd = 0; d_gntd = 0;
    exp_crd = 32'd0; exp_drd = 32'd0; p_owner = 0; p_we = 0; p_addr = 32'd0; p_wdata = 32'd0;
    for (int c = 0; c < 406; c++) begin
      @(posedge clk); #1;
      if (c_gntd || !c_hold) begin
        c_hold = (c < 400) && ($urandom_range(0, 2) != 0);
        core_req = c_hold; core_we = 1'($urandom_range(0, 1));
        core_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; core_wdata = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        c_hold = 0; core_req = 1'b0;
      end
      if (d_gntd || !d_hold) begin
        d_hold = (c < 400) && ($urandom_range(0, 2) != 0);
        dbg_req = d_hold; dbg_we = 1'($urandom_range(0, 1));
        dbg_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; dbg_wdata = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        d_hold = 0; dbg_req = 1'b0;
      end
      @(negedge clk);
      // Reference timing: ACCESS one cycle after grant, response L+2 = 3 cycles after grant.
      resp = busy && (c == g + 3);
      acc  = busy && (c == g + 1);
      if (resp && p_we) ref_mem[p_addr[7:0]] = p_wdata;
      if (resp && !p_we && !p_owner) exp_crd = ref_mem[p_addr[7:0]];
      if (resp && !p_we && p_owner) exp_drd = ref_mem[p_addr[7:0]];
      n_checks++;
      if ({core_rvalid, dbg_rvalid} !== {resp && !p_owner, resp && p_owner})
        $display("FAIL rnd_rvalid: cycle %0d got %b%b want %b%b", c, core_rvalid, dbg_rvalid, resp && !p_owner, resp && p_owner);
      else n_pass++;
      n_checks++;
      if ({core_rdata, dbg_rdata} !== {exp_crd, exp_drd})
        $display("FAIL rnd_rdata: cycle %0d got %h %h want %h %h", c, core_rdata, dbg_rdata, exp_crd, exp_drd);
      else n_pass++;
      n_checks++;
      if ({mem_en, mem_we} !== {acc, acc && p_we})
        $display("FAIL rnd_mem_en: cycle %0d got %b%b want %b%b", c, mem_en, mem_we, acc, acc && p_we);
      else n_pass++;
      if (acc) begin
        n_checks++;
        if (mem_addr !== p_addr || (p_we && mem_wdata !== p_wdata))
          $display("FAIL rnd_mem_bus: cycle %0d got %h %h want %h %h", c, mem_addr, mem_wdata, p_addr, p_wdata);
        else n_pass++;
      end
      ec = (!busy || resp) && core_req && (!dbg_req || last_dbg);
      ed = (!busy || resp) && dbg_req && (!core_req || !last_dbg);
      n_checks++;
      if ({core_gnt, dbg_gnt} !== {ec, ed})
        $display("FAIL rnd_gnt: cycle %0d got %b%b want %b%b", c, core_gnt, dbg_gnt, ec, ed);
      else n_pass++;
      if (resp) busy = 0;
      c_gntd = ec; d_gntd = ed;
      if (ec || ed) begin
        busy = 1; g = c; p_owner = ed; last_dbg = ed;
        p_we = ed ? dbg_we : core_we;
        p_addr = ed ? dbg_addr : core_addr;
        p_wdata = ed ? dbg_wdata : core_wdata;
      end
    end
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_dbg_write_core_read();
    test_alternate();
    test_reset_mid();
    test_cancel();
    test_latency();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the core's single unified memory port between two requesters:
- the multicycle core (instruction fetch and load/store accesses issued by the control FSM);
- a debug/loader port that preloads programs and inspects memory while the core runs or is held.

The block accepts one request at a time, sequences the memory access and its read latency, and returns a one-cycle response. Arbitration is round-robin so neither side starves.

Parameters:
ADDR_W, 32, address width (byte address, passed through unchanged)
DATA_W, 32, data width
MEM_LATENCY, 1, cycles from the memory-enable cycle until mem_rdata is valid; legal range 0..3

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
core_req  in  1  core requests an access
core_we  in  1  1 = write, 0 = read
core_addr  in  ADDR_W  core access address
core_wdata  in  DATA_W  core write data
core_gnt  out  1  core request accepted this cycle
core_rvalid  out  1  core response valid (read data or write ack)
core_rdata  out  DATA_W  core read data
dbg_req  in  1  debug requests an access
dbg_we  in  1  debug write enable
dbg_addr  in  ADDR_W  debug access address
dbg_wdata  in  DATA_W  debug write data
dbg_gnt  out  1  debug request accepted this cycle
dbg_rvalid  out  1  debug response valid
dbg_rdata  out  DATA_W  debug read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data

Behaviour:
- FSM states: IDLE, ACCESS, WAIT, RESP.
- Reset (reset==0 at a clock edge):
  - state goes to IDLE and any in-flight access is dropped with no response;
  - round-robin pointer is set to favour the core;
  - all outputs are 0, including the rdata registers.
- Arbitration happens only in IDLE and RESP.
- gnt is combinational and only asserted in IDLE or RESP. It is a one-hot one-cycle pulse:
  - one requester active: that requester is granted;
  - both active: the requester not granted last is granted;
  - after reset, the core is treated as not granted last, so the core wins the first tie.
- Requester handshake:
  - hold req, we, addr and wdata stable until gnt is seen;
  - may drop req or change the fields in the cycle after gnt.
- On the grant edge, we/addr/wdata and the requester id are registered and the FSM moves to ACCESS.
- ACCESS (exactly 1 cycle): mem_en=1; mem_we, mem_addr and mem_wdata are driven from the registers. In every other state mem_en=0 and mem_we=0; mem_addr and mem_wdata hold their last values.
- Next state after ACCESS:
  - MEM_LATENCY==0: mem_rdata is sampled at the end of ACCESS, then RESP;
  - otherwise: WAIT for MEM_LATENCY cycles (down-counter), mem_rdata sampled at the end of the last WAIT cycle, then RESP.
- Writes follow the same timing, with no rdata capture.
- RESP (1 cycle): the owner's rvalid=1. For a read, the owner's rdata register is updated; the other requester's rdata is unchanged. rdata holds its value until the next read completes for that requester.
- Throughput (MEM_LATENCY=L):
  - grant cycle T, ACCESS T+1, RESP T+2+L;
  - a new grant may occur in RESP, giving back-to-back accesses every L+2 cycles.
- A req seen in ACCESS or WAIT is not granted; it waits. req deasserting before gnt cancels that request silently.
- Both rvalid outputs are never high in the same cycle, and gnt is never asserted to both requesters in one cycle.
- Reset takes priority over every other event, including a grant in the same cycle.

Decomposition:
- Package mem_arbiter_pkg:
  - state enum (IDLE, ACCESS, WAIT, RESP);
  - requester id typedef (REQ_CORE=0, REQ_DBG=1);
  - a localparam for the latency counter width.
- A sub-module rr_picker (2-input round-robin grant with last-grant pointer) is natural and independently testable. Everything else stays in mem_arbiter.

Test Plan:
- Memory model preloaded with M[42]=deadbeef, MEM_LATENCY=1; core read addr 0x2a with dbg idle -> core_gnt at T, mem_en at T+1 with mem_addr=0x2a, core_rvalid at T+3 with core_rdata=deadbeef; dbg_rvalid stays 0.
- Dbg write addr 0x10 data cafef00d, then core read 0x10 -> mem_we=1 only in the dbg ACCESS cycle; core read returns cafef00d.
- Both req high continuously out of reset -> grants alternate core, dbg, core, dbg; consecutive grants are 3 cycles apart (L=1); there are no double grants.
- Reset driven low during WAIT of a core read -> no core_rvalid; all outputs 0 the next cycle; after release a pending dbg+core tie grants core first.
- MEM_LATENCY=0 and MEM_LATENCY=3 builds, single read each -> RESP at T+2 and T+5 respectively with correct data.
- dbg_req pulsed one cycle during a core ACCESS then dropped -> no dbg_gnt and no dbg_rvalid ever.
